// File: rtl/sclkfifolut_reader_pkg.sv
// Shared constants for the sclkfifolut reader family: FIFO read latency and skid depth.
// Also provides the occupancy helper used by the read-issue rule.
package sclkfifolut_reader_pkg;

  localparam int unsigned SCLKFIFOLUT_RD_LATENCY = 1;
  localparam int unsigned SKID_DEPTH             = 2;
  localparam int unsigned SB_CNT_W               = $clog2(SKID_DEPTH + 1);

  typedef logic [SB_CNT_W-1:0] sb_cnt_t;
  typedef logic [SB_CNT_W:0]   occ_t;

  localparam sb_cnt_t SB_FULL       = sb_cnt_t'(SKID_DEPTH);
  // A read may issue only if its word still has a slot when it lands.
  localparam occ_t    OCC_ISSUE_MAX = occ_t'(SKID_DEPTH - SCLKFIFOLUT_RD_LATENCY);

  function automatic occ_t occ_after(input sb_cnt_t cnt, input logic inflight, input logic pop);
    return {1'b0, cnt} + {{SB_CNT_W{1'b0}}, inflight} - {{SB_CNT_W{1'b0}}, pop};
  endfunction

endpackage

// File: rtl/sclkfifolut_skid2.sv
// Two-entry in-order register buffer with push/pop, occupancy count and registered head.
module sclkfifolut_skid2
  import sclkfifolut_reader_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             arst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output sb_cnt_t          cnt,
  output logic             valid,
  output logic [WIDTH-1:0] head
);

  logic [WIDTH-1:0] ent0_q, ent0_d;
  logic [WIDTH-1:0] ent1_q, ent1_d;
  sb_cnt_t          cnt_q, cnt_d;

  always_comb begin
    ent0_d = ent0_q;
    ent1_d = ent1_q;
    cnt_d  = cnt_q;
    case ({push, pop})
      2'b10: begin
        if (cnt_q == '0) ent0_d = push_data;
        else             ent1_d = push_data;
        cnt_d = cnt_q + 1'b1;
      end
      2'b01: begin
        ent0_d = ent1_q;
        cnt_d  = cnt_q - 1'b1;
      end
      2'b11: begin
        // Count holds; the new word goes behind whatever remains.
        if (cnt_q == SB_FULL) begin
          ent0_d = ent1_q;
          ent1_d = push_data;
        end else begin
          ent0_d = push_data;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      ent0_q <= '0;
      ent1_q <= '0;
      cnt_q  <= '0;
    end else begin
      ent0_q <= ent0_d;
      ent1_q <= ent1_d;
      cnt_q  <= cnt_d;
    end
  end

  assign cnt   = cnt_q;
  assign valid = (cnt_q != '0);
  assign head  = ent0_q;

  overflow_a: assert property (@(posedge clk) disable iff (!arst_n)
    !(push && !pop && cnt_q == SB_FULL));

endmodule

// File: rtl/sclkfifolut_reader.sv
// Drains an sclkfifolut into a valid/ready stream, hiding the FIFO read latency in a skid buffer.
// Optional delivered-word counter enabled by SCLKFIFOLUT_READER_WORDCNT_EN.
module sclkfifolut_reader
  import sclkfifolut_reader_pkg::*;
#(
  parameter int unsigned FIFO_WIDTH = 32,
  parameter int unsigned CNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  arst_n,
  input  logic                  drain_en,
  output logic                  fifo_ren,
  input  logic [FIFO_WIDTH-1:0] fifo_rdata,
  input  logic                  fifo_rempty,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [FIFO_WIDTH-1:0] out_data
`ifdef SCLKFIFOLUT_READER_WORDCNT_EN
  ,
  output logic [CNT_WIDTH-1:0]  word_cnt
`endif
);

  logic    inflight_q, inflight_d;
  logic    pop;
  sb_cnt_t sb_cnt;

  assign pop = out_valid & out_ready;

  always_comb begin
    fifo_ren   = drain_en & ~fifo_rempty &
                 (occ_after(sb_cnt, inflight_q, pop) <= OCC_ISSUE_MAX);
    inflight_d = fifo_ren;
  end

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) inflight_q <= 1'b0;
    else         inflight_q <= inflight_d;
  end

  sclkfifolut_skid2 #(
    .WIDTH (FIFO_WIDTH)
  ) u_skid (
    .clk       (clk),
    .arst_n    (arst_n),
    .push      (inflight_q),
    .push_data (fifo_rdata),
    .pop       (pop),
    .cnt       (sb_cnt),
    .valid     (out_valid),
    .head      (out_data)
  );

`ifdef SCLKFIFOLUT_READER_WORDCNT_EN
  logic [CNT_WIDTH-1:0] word_cnt_q, word_cnt_d;

  always_comb begin
    word_cnt_d = pop ? word_cnt_q + 1'b1 : word_cnt_q;
  end

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) word_cnt_q <= '0;
    else         word_cnt_q <= word_cnt_d;
  end

  assign word_cnt = word_cnt_q;
`endif

endmodule

// File: tb/tb_sclkfifolut_reader.sv
// Directed bench for sclkfifolut_reader with a behavioural depth-8 FIFO in front of it.
// Define SCLKFIFOLUT_READER_WORDCNT_EN to also exercise the word counter (CNT_WIDTH=3).
module tb_sclkfifolut_reader;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         arst_n = 1'b1;
  logic         drain_en = 1'b0;
  logic         out_ready = 1'b0;
  logic         fifo_ren, fifo_rempty, out_valid;
  logic [W-1:0] fifo_rdata, out_data;
`ifdef SCLKFIFOLUT_READER_WORDCNT_EN
  logic [2:0]   word_cnt;
`endif

  always #5 clk = ~clk;

  sclkfifolut_reader #(.FIFO_WIDTH(W), .CNT_WIDTH(3)) dut (
    .clk         (clk),
    .arst_n      (arst_n),
    .drain_en    (drain_en),
    .fifo_ren    (fifo_ren),
    .fifo_rdata  (fifo_rdata),
    .fifo_rempty (fifo_rempty),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_data    (out_data)
`ifdef SCLKFIFOLUT_READER_WORDCNT_EN
    ,
    .word_cnt    (word_cnt)
`endif
  );

  // behavioural FIFO, reset together with the reader
  logic [W-1:0] mem [8];
  logic [2:0]   wr_ptr, rd_ptr;
  int           level;
  logic         wen = 1'b0;
  logic [W-1:0] wdata = '0;

  assign fifo_rempty = (level == 0);

  always @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      wr_ptr <= '0; rd_ptr <= '0; level <= 0; fifo_rdata <= '0;
    end else begin
      if (wen) begin mem[wr_ptr] <= wdata; wr_ptr <= wr_ptr + 3'd1; end
      if (fifo_ren) begin fifo_rdata <= mem[rd_ptr]; rd_ptr <= rd_ptr + 3'd1; end
      level <= level + int'(wen) - int'(fifo_ren);
    end
  end

  // monitor: delivered words, read count, protocol violations
  int           ren_total, pop_total;
  int           viol = 0;
  logic [W-1:0] popped [$];

  always @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      ren_total <= 0; pop_total <= 0;
    end else begin
      viol <= viol + int'(fifo_ren && fifo_rempty) +
              int'((ren_total + int'(fifo_ren)) - (pop_total + int'(out_valid && out_ready)) > 2);
      ren_total <= ren_total + int'(fifo_ren);
      if (out_valid && out_ready) begin
        popped.push_back(out_data);
        pop_total <= pop_total + 1;
      end
    end
  end

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic load(input int n, input logic [W-1:0] base);
    drain_en = 1'b0;
    for (int i = 0; i < n; i++) begin
      wen = 1'b1; wdata = base + W'(i);
      @(negedge clk);
    end
    wen = 1'b0;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  task automatic chk_popped(input string nm, input int n, input logic [W-1:0] base);
    chk({nm, " count"}, W'(popped.size()), W'(n));
    for (int i = 0; i < n && i < popped.size(); i++)
      chk($sformatf("%s word%0d", nm, i), popped[i], base + W'(i));
  endtask

  typedef struct {
    logic         de;
    logic         rdy;
    logic         ren;
    logic         vld;
    logic [W-1:0] data;
  } vec_t;

  vec_t stream_v [11];
  logic [W-1:0] r0;

  initial begin
    stream_v[0]  = '{1'b1, 1'b1, 1'b1, 1'b0, '0};
    stream_v[1]  = '{1'b1, 1'b1, 1'b1, 1'b0, '0};
    for (int c = 2; c < 8; c++) stream_v[c] = '{1'b1, 1'b1, 1'b1, 1'b1, W'(c - 1)};
    stream_v[8]  = '{1'b1, 1'b1, 1'b0, 1'b1, 32'h7};
    stream_v[9]  = '{1'b1, 1'b1, 1'b0, 1'b1, 32'h8};
    stream_v[10] = '{1'b1, 1'b1, 1'b0, 1'b0, '0};

    // reset asserted mid-cycle, then idle with an empty FIFO
    #12 arst_n = 1'b0;
    #1;
    chk("rst ren", W'(fifo_ren), '0);
    chk("rst valid", W'(out_valid), '0);
    chk("rst data", out_data, '0);
    @(negedge clk);
    arst_n = 1'b1;
    drain_en = 1'b1; out_ready = 1'b1;
    for (int c = 0; c < 6; c++) begin
      #1;
      chk($sformatf("idle ren c%0d", c), W'(fifo_ren), '0);
      chk($sformatf("idle valid c%0d", c), W'(out_valid), '0);
      @(negedge clk);
    end

    // streaming, cycle-accurate table
    load(8, 32'h1);
    popped.delete();
    for (int c = 0; c < 11; c++) begin
      drain_en = stream_v[c].de; out_ready = stream_v[c].rdy;
      #1;
      chk($sformatf("stream ren c%0d", c), W'(fifo_ren), W'(stream_v[c].ren));
      chk($sformatf("stream valid c%0d", c), W'(out_valid), W'(stream_v[c].vld));
      if (stream_v[c].vld) chk($sformatf("stream data c%0d", c), out_data, stream_v[c].data);
      @(negedge clk);
    end
    chk_popped("stream", 8, 32'h1);

    // backpressure: only two words leave the FIFO, head held
    out_ready = 1'b0;
    load(8, 32'h1);
    popped.delete();
    r0 = W'(ren_total);
    drain_en = 1'b1;
    for (int c = 0; c < 10; c++) begin
      #1;
      if (c >= 2) begin
        chk($sformatf("bp valid c%0d", c), W'(out_valid), 32'h1);
        chk($sformatf("bp data c%0d", c), out_data, 32'h1);
      end
      @(negedge clk);
    end
    chk("bp ren pulses", W'(ren_total) - r0, 32'd2);
    chk("bp fifo level", W'(level), 32'd6);
    out_ready = 1'b1;
    run(20);
    chk_popped("bp", 8, 32'h1);

    // toggling ready
    out_ready = 1'b0;
    load(8, 32'h1);
    popped.delete();
    drain_en = 1'b1;
    for (int c = 0; c < 40; c++) begin
      out_ready = (c % 2 == 0);
      @(negedge clk);
    end
    chk_popped("toggle", 8, 32'h1);

    // drain_en falling: issued reads still land and drain
    out_ready = 1'b0;
    load(4, 32'h10);
    popped.delete();
    drain_en = 1'b1;
    run(2);
    drain_en = 1'b0;
    run(5);
    chk("drain_off level", W'(level), 32'd2);
    out_ready = 1'b1;
    run(5);
    chk_popped("drain_off", 2, 32'h10);
    drain_en = 1'b1;
    run(10);
    chk_popped("drain_on", 4, 32'h10);

    // reset mid-stream with buffered and in-flight words
    out_ready = 1'b0;
    load(4, 32'h30);
    drain_en = 1'b1;
    run(2);
    #2 arst_n = 1'b0;
    #1;
    chk("midrst valid", W'(out_valid), '0);
    chk("midrst ren", W'(fifo_ren), '0);
    chk("midrst data", out_data, '0);
    @(negedge clk);
    arst_n = 1'b1;
    popped.delete();
    load(1, 32'h25);
    drain_en = 1'b1; out_ready = 1'b1;
    run(6);
    chk_popped("post_rst", 1, 32'h25);

    chk("no protocol violations", W'(viol), '0);

`ifdef SCLKFIFOLUT_READER_WORDCNT_EN
    @(negedge clk);
    arst_n = 1'b0;
    @(negedge clk);
    arst_n = 1'b1;
    popped.delete();
    load(8, 32'h40);
    drain_en = 1'b1; out_ready = 1'b1;
    run(12);
    load(2, 32'h48);
    drain_en = 1'b1;
    run(6);
    chk_popped("wordcnt stream", 10, 32'h40);
    chk("word_cnt wrap", W'(word_cnt), 32'd2);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
